// File: rtl/serial_add_sub_if.sv
// rtl/serial_add_sub_if.sv - request/result bundle for the bit-serial adder/subtractor
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, one bit per clock; optional SERIAL_ADD_SUB_OVERFLOW_EN
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_add_sub_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             cout_r;
    logic             accept;
    logic             last_bit;
    logic             bit_s;
    logic             bit_c;

    assign accept   = bus.start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign bit_s    = op_a[0] ^ op_b[0] ^ carry;
    assign bit_c    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtract is a + ~b + 1: invert B on entry and seed the carry with the mode bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else if (accept) begin
            op_a   <= bus.a;
            op_b   <= bus.b ^ {WIDTH{bus.sub}};
            carry  <= bus.sub;
            cnt    <= '0;
            sum_r  <= '0;
        end else if (state == RUN) begin
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            sum_r  <= {bit_s, sum_r[WIDTH-1:1]};
            carry  <= bit_c;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout_r <= bit_c;
            end
        end
    end

`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic ovf_r;

    // On the MSB cycle the carry flop still holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            ovf_r <= carry ^ bit_c;
        end
    end

    assign bus.overflow = ovf_r;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - directed and exhaustive checks for serial_add_sub
module tb_serial_add_sub;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    serial_add_sub_if #(.WIDTH(8)) bus8 ();
    serial_add_sub_if #(.WIDTH(4)) bus4 ();

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_add_sub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one 8-bit operation; b2b means we are already at the done negedge of a prior op.
    task automatic do_op8(input string tag, input bit s, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_sum, input bit exp_cout, input bit exp_ovf,
                          input int glitch, input bit b2b);
        int n;
        int busy_cnt;
        if (!b2b) @(negedge clk);
        bus8.a = av;
        bus8.b = bv;
        bus8.sub = s;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!bus8.done && n < 40) begin
            if (bus8.busy) busy_cnt++;
            if (glitch != 0 && n == glitch) begin
                bus8.start = 1'b1;
                bus8.a = 8'hFF;
                bus8.b = 8'hFF;
                bus8.sub = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus8.start = 1'b0;
        check_eq({tag, "_latency"}, 64'(n), 64'd9);
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
        check_eq({tag, "_sum"}, 64'(bus8.sum), 64'(exp_sum));
        check_eq({tag, "_cout"}, 64'(bus8.cout), 64'(exp_cout));
        check_eq({tag, "_ovf"}, 64'(bus8.overflow), 64'(exp_ovf));
    endtask

    initial begin
        int seen_done;
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(bus8.busy), 64'd0);
        check_eq("rst_done", 64'(bus8.done), 64'd0);
        check_eq("rst_sum", 64'(bus8.sum), 64'd0);
        check_eq("rst_cout", 64'(bus8.cout), 64'd0);
        check_eq("rst_ovf", 64'(bus8.overflow), 64'd0);
        rst_n = 1'b1;

        do_op8("add_3c_0f", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        check_eq("done_one_cycle", 64'(bus8.done), 64'd0);
        check_eq("sum_hold", 64'(bus8.sum), 64'h4B);
        do_op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        do_op8("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0, 1'b0);
        do_op8("sub_07_05", 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0, 0, 1'b0);
        do_op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, OVF_EN, 0, 1'b0);
        do_op8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, OVF_EN, 0, 1'b0);
        do_op8("glitch", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 3, 1'b0);

        do_op8("b2b_first", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0, 1'b0);
        do_op8("b2b_second", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        check_eq("b2b_done_drop", 64'(bus8.done), 64'd0);
        check_eq("b2b_idle", 64'(bus8.busy), 64'd0);

        do_op8("pre_reset", 1'b0, 8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        bus8.a = 8'h55; bus8.b = 8'h11; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(bus8.busy), 64'd0);
        check_eq("midrst_done", 64'(bus8.done), 64'd0);
        check_eq("midrst_sum", 64'(bus8.sum), 64'd0);
        check_eq("midrst_cout", 64'(bus8.cout), 64'd0);
        check_eq("midrst_ovf", 64'(bus8.overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done) seen_done++;
        end
        check_eq("midrst_no_done", 64'(seen_done), 64'd0);
        check_eq("midrst_idle", 64'(bus8.busy), 64'd0);

        for (int s = 0; s < 2; s++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    int n;
                    logic [3:0] bx;
                    logic [4:0] full;
                    logic exp_ovf;
                    bit ok;
                    @(negedge clk);
                    bus4.a = 4'(av);
                    bus4.b = 4'(bv);
                    bus4.sub = s[0];
                    bus4.start = 1'b1;
                    @(negedge clk);
                    bus4.start = 1'b0;
                    n = 1;
                    while (!bus4.done && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    bx = (s != 0) ? ~4'(bv) : 4'(bv);
                    full = 5'(av) + 5'(bx) + 5'(s);
                    exp_ovf = OVF_EN && (av[3] == bx[3]) && (full[3] != av[3]);
                    ok = (bus4.done === 1'b1) && (bus4.sum === full[3:0]) &&
                         (bus4.cout === full[4]) && (bus4.overflow === exp_ovf);
                    $display("[TB] w4 %s a=%h b=%h sum=%h cout=%b ovf=%b %s",
                             (s != 0) ? "sub" : "add", av[3:0], bv[3:0], bus4.sum,
                             bus4.cout, bus4.overflow, ok ? "ok" : "FALSE");
                    check_eq("w4_done", 64'(bus4.done), 64'd1);
                    check_eq("w4_sum", 64'(bus4.sum), 64'(full[3:0]));
                    check_eq("w4_cout", 64'(bus4.cout), 64'(full[4]));
                    check_eq("w4_ovf", 64'(bus4.overflow), 64'(exp_ovf));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
